// File: rtl/spi_xfer_arbiter.sv
// rtl/spi_xfer_arbiter.sv - round-robin sharing of the SPI_0 master between NUM_REQ requesters
// Optional poll timeout: define SPI_XFER_ARB_TIMEOUT_EN.
module spi_xfer_arbiter #(
    parameter int          NUM_REQ    = 2,
    parameter logic [7:0]  SPCR_INIT  = 8'h50,
    parameter logic [5:0]  SPCR_ADDR  = 6'h2C,
    parameter logic [5:0]  SPSR_ADDR  = 6'h2D,
    parameter logic [5:0]  SPDR_ADDR  = 6'h2E,
    parameter int          POLL_LIMIT = 1024
) (
    input  logic                   cp2,
    input  logic                   ireset,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [NUM_REQ-1:0]     req_hold,
    input  logic [8*NUM_REQ-1:0]   req_tx,
    output logic [NUM_REQ-1:0]     ack,
    output logic [7:0]             rx_data,
    output logic [NUM_REQ-1:0]     cs_n,
    output logic [5:0]             io_addr,
    output logic                   iowe,
    output logic                   iore,
    output logic [7:0]             dbus_out,
    input  logic [7:0]             dbus_in,
    output logic                   busy,
    output logic                   err
);
    localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [3:0] {
        S_CFG, S_IDLE, S_ARB, S_SETUP, S_WR, S_POLL, S_CHK, S_RD, S_ACK
    } state_t;

    state_t          state, next_state;
    logic [OW-1:0]   owner;
    logic            owner_valid;
    logic [OW-1:0]   rr_ptr;
    logic [OW-1:0]   owner_inc;
    logic            hold_q;
    logic            spif_q;
    logic [7:0]      rx_q;
    logic            grant_found;
    logic [OW-1:0]   grant_idx;
    logic            to_hit;
    logic            to_q;

    assign owner_inc = (int'(owner) == NUM_REQ - 1) ? '0 : owner + OW'(1);

`ifdef SPI_XFER_ARB_TIMEOUT_EN
    localparam int PW = $clog2(POLL_LIMIT + 1);
    logic [PW-1:0] poll_cnt;

    assign to_hit = (poll_cnt == PW'(POLL_LIMIT - 1));

    always_ff @(posedge cp2) begin
        if (ireset) begin
            poll_cnt <= '0;
            to_q     <= 1'b0;
            err      <= 1'b0;
        end else if (state == S_WR) begin
            poll_cnt <= '0;
            to_q     <= 1'b0;
        end else if (state == S_CHK && !spif_q) begin
            if (to_hit) begin
                to_q <= 1'b1;
                err  <= 1'b1;
            end else begin
                poll_cnt <= poll_cnt + PW'(1);
            end
        end
    end
`else
    assign to_hit = 1'b0;
    assign to_q   = 1'b0;
    assign err    = 1'b0;
`endif

    // First requester at or after rr_ptr, wrapping at NUM_REQ.
    always_comb begin
        int idx;
        grant_found = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!grant_found && req[idx]) begin
                grant_found = 1'b1;
                grant_idx   = OW'(idx);
            end
        end
    end

    always_ff @(posedge cp2) begin
        if (ireset) state <= S_CFG;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_CFG:   next_state = S_IDLE;
            S_IDLE: begin
                if (owner_valid && req[owner]) next_state = S_WR;
                else if (|req)                 next_state = S_ARB;
            end
            S_ARB:   next_state = grant_found ? S_SETUP : S_IDLE;
            S_SETUP: next_state = S_WR;
            S_WR:    next_state = S_POLL;
            S_POLL:  next_state = S_CHK;
            S_CHK: begin
                if (spif_q)      next_state = S_RD;
                else if (to_hit) next_state = S_ACK;
                else             next_state = S_POLL;
            end
            S_RD:    next_state = S_ACK;
            S_ACK:   next_state = to_q ? S_CFG : S_IDLE;
            default: next_state = S_CFG;
        endcase
    end

    always_ff @(posedge cp2) begin
        if (ireset) begin
            owner       <= '0;
            owner_valid <= 1'b0;
            rr_ptr      <= '0;
            hold_q      <= 1'b0;
            spif_q      <= 1'b0;
            rx_q        <= 8'h00;
        end else begin
            case (state)
                S_IDLE: begin
                    // A holding owner that withdrew its request gives up the bus.
                    if (owner_valid && !req[owner]) begin
                        owner_valid <= 1'b0;
                        rr_ptr      <= owner_inc;
                    end
                end
                S_ARB: begin
                    if (grant_found) begin
                        owner       <= grant_idx;
                        owner_valid <= 1'b1;
                    end
                end
                S_WR:   hold_q <= req_hold[owner];
                S_POLL: spif_q <= dbus_in[7];
                S_CHK: begin
                    if (!spif_q && to_hit) rx_q <= 8'hFF;
                end
                S_RD:   rx_q <= dbus_in;
                S_ACK: begin
                    if (!hold_q || to_q) begin
                        owner_valid <= 1'b0;
                        rr_ptr      <= owner_inc;
                    end
                end
                default: ;
            endcase
        end
    end

    // The SPCR strobe is held off while reset is asserted so it is a single pulse.
    always_comb begin
        iowe     = 1'b0;
        iore     = 1'b0;
        io_addr  = 6'h00;
        dbus_out = 8'h00;
        ack      = '0;
        case (state)
            S_CFG: begin
                if (!ireset) begin
                    iowe     = 1'b1;
                    io_addr  = SPCR_ADDR;
                    dbus_out = SPCR_INIT;
                end
            end
            S_WR: begin
                iowe     = 1'b1;
                io_addr  = SPDR_ADDR;
                dbus_out = req_tx[8*int'(owner) +: 8];
            end
            S_POLL: begin
                iore    = 1'b1;
                io_addr = SPSR_ADDR;
            end
            S_RD: begin
                iore    = 1'b1;
                io_addr = SPDR_ADDR;
            end
            S_ACK:   ack[owner] = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        cs_n = '1;
        if (owner_valid) cs_n[owner] = 1'b0;
    end

    assign busy    = (state != S_IDLE);
    assign rx_data = rx_q;

endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// tb/tb_spi_xfer_arbiter.sv - scoreboard bench for spi_xfer_arbiter with an SPI_0 slave model
module tb_spi_xfer_arbiter;
    localparam int N = 2;
`ifdef SPI_XFER_ARB_TIMEOUT_EN
    localparam int PL = 4;
`else
    localparam int PL = 1024;
`endif

    logic           cp2 = 1'b0;
    logic           ireset;
    logic [N-1:0]   req;
    logic [N-1:0]   req_hold;
    logic [8*N-1:0] req_tx;
    logic [N-1:0]   ack;
    logic [7:0]     rx_data;
    logic [N-1:0]   cs_n;
    logic [5:0]     io_addr;
    logic           iowe;
    logic           iore;
    logic [7:0]     dbus_out;
    logic [7:0]     dbus_in;
    logic           busy;
    logic           err;

    spi_xfer_arbiter #(.NUM_REQ(N), .POLL_LIMIT(PL)) dut (
        .cp2(cp2), .ireset(ireset), .req(req), .req_hold(req_hold), .req_tx(req_tx),
        .ack(ack), .rx_data(rx_data), .cs_n(cs_n), .io_addr(io_addr), .iowe(iowe),
        .iore(iore), .dbus_out(dbus_out), .dbus_in(dbus_in), .busy(busy), .err(err)
    );

    always #5 cp2 = ~cp2;

    // Slave: SPIF rises after ready_polls status reads; MISO byte is the sent byte xor 8'h99.
    logic [7:0] last_tx = 8'h00;
    logic [1:0] cs_at_wr = 2'b11;
    int polls_done = 0;
    int ready_polls = 0;
    int cs_bad = 0;
    int cs1_high = 0;

    always @(posedge cp2) begin
        if (iowe && io_addr == 6'h2E) begin
            last_tx    <= dbus_out;
            cs_at_wr   <= cs_n;
            polls_done <= 0;
        end else if (iore && io_addr == 6'h2D) begin
            polls_done <= polls_done + 1;
        end
    end

    assign dbus_in = (io_addr == 6'h2D) ? {(polls_done >= ready_polls), 7'b0} :
                     (io_addr == 6'h2E) ? (last_tx ^ 8'h99) : 8'h00;

    always @(negedge cp2) begin
        if ($countones(~cs_n) > 1) cs_bad <= cs_bad + 1;
        if (cs_n[1]) cs1_high <= cs1_high + 1;
    end

    int n_checks = 0;
    int n_fail = 0;
    logic [9:0] exp_q[$];

    task automatic step;
        @(posedge cp2);
        #1;
    endtask

    task automatic do_reset;
        ireset = 1'b1; req = '0; req_hold = '0; req_tx = '0;
        step; step;
        ireset = 1'b0;
        exp_q.delete();
    endtask

    task automatic wait_ack(input int budget, output bit ok, output int cyc);
        ok = 1'b0; cyc = 0;
        while (!ok && cyc < budget) begin
            step;
            cyc++;
            if (ack != '0) ok = 1'b1;
        end
    endtask

    task automatic test_reset;
        ireset = 1'b1; req = '0; req_hold = '0; req_tx = '0;
        step; step;
        n_checks++;
        if ({ack, cs_n, iowe, iore, io_addr, dbus_out, busy, err, rx_data} !==
            {2'b00, 2'b11, 1'b0, 1'b0, 6'h00, 8'h00, 1'b1, 1'b0, 8'h00}) begin
            n_fail++;
            $display("FAIL reset_values got ack=%b cs_n=%b iowe=%b iore=%b addr=%h dout=%h busy=%b err=%b rx=%h",
                     ack, cs_n, iowe, iore, io_addr, dbus_out, busy, err, rx_data);
        end
        ireset = 1'b0;
        #1;
        n_checks++;
        if ({iowe, iore, io_addr, dbus_out, busy} !== {1'b1, 1'b0, 6'h2C, 8'h50, 1'b1}) begin
            n_fail++;
            $display("FAIL spcr_write got iowe=%b iore=%b addr=%h dout=%h busy=%b want 1 0 2c 50 1",
                     iowe, iore, io_addr, dbus_out, busy);
        end
        step;
        n_checks++;
        if ({busy, cs_n, iowe, iore} !== {1'b0, 2'b11, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL idle_after_cfg got busy=%b cs_n=%b iowe=%b iore=%b want 0 11 0 0",
                     busy, cs_n, iowe, iore);
        end
    endtask

    task automatic test_single;
        bit ok; int cyc; logic [9:0] e;
        do_reset; step;
        ready_polls = 2;
        req_tx[7:0] = 8'hA5;
        req = 2'b01;
        exp_q.push_back({2'b01, 8'hA5 ^ 8'h99});
        wait_ack(60, ok, cyc);
        req = '0;
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL single_ack got timeout want ack within 60 cycles");
        end else begin
            e = exp_q.pop_front();
            if ({ack, rx_data} !== e) begin
                n_fail++;
                $display("FAIL single_ack got ack=%b rx=%h want ack=%b rx=%h", ack, rx_data, e[9:8], e[7:0]);
            end
        end
        n_checks++;
        if (rx_data !== 8'h3C) begin
            n_fail++;
            $display("FAIL single_rx got %h want 3c", rx_data);
        end
        n_checks++;
        if ({last_tx, cs_at_wr} !== {8'hA5, 2'b10}) begin
            n_fail++;
            $display("FAIL single_spdr_write got tx=%h cs_n=%b want a5 10", last_tx, cs_at_wr);
        end
        step;
        n_checks++;
        if (ack !== 2'b00) begin
            n_fail++;
            $display("FAIL single_ack_pulse got ack=%b want 00", ack);
        end
        step;
        n_checks++;
        if ({cs_n, busy} !== {2'b11, 1'b0}) begin
            n_fail++;
            $display("FAIL single_release got cs_n=%b busy=%b want 11 0", cs_n, busy);
        end
    endtask

    task automatic test_latency;
        bit ok; int cyc; logic [9:0] e;
        do_reset; step;
        ready_polls = 0;
        req_tx[15:8] = 8'h5A;
        req = 2'b10;
        exp_q.push_back({2'b10, 8'h5A ^ 8'h99});
        wait_ack(30, ok, cyc);
        req = '0;
        n_checks++;
        if (!ok || cyc != 7) begin
            n_fail++;
            $display("FAIL min_latency got ok=%0d cycles=%0d want 7", ok, cyc);
        end
        n_checks++;
        e = exp_q.pop_front();
        if ({ack, rx_data} !== e) begin
            n_fail++;
            $display("FAIL latency_data got ack=%b rx=%h want ack=%b rx=%h", ack, rx_data, e[9:8], e[7:0]);
        end
        step; step;
    endtask

    task automatic test_round_robin;
        bit ok; int cyc; int bad0; logic [9:0] e;
        do_reset; step;
        ready_polls = 1;
        req_tx = {8'h22, 8'h11};
        for (int i = 0; i < 4; i++)
            exp_q.push_back((i % 2 == 0) ? {2'b01, 8'h11 ^ 8'h99} : {2'b10, 8'h22 ^ 8'h99});
        bad0 = cs_bad;
        req = 2'b11;
        for (int i = 0; i < 4; i++) begin
            wait_ack(60, ok, cyc);
            n_checks++;
            if (!ok) begin
                n_fail++;
                $display("FAIL rr_grant%0d got timeout want ack", i);
            end else begin
                e = exp_q.pop_front();
                if ({ack, rx_data} !== e) begin
                    n_fail++;
                    $display("FAIL rr_grant%0d got ack=%b rx=%h want ack=%b rx=%h",
                             i, ack, rx_data, e[9:8], e[7:0]);
                end
            end
        end
        req = '0;
        step; step;
        n_checks++;
        if (cs_bad != bad0) begin
            n_fail++;
            $display("FAIL rr_cs_onehot got %0d multi-select cycles want 0", cs_bad - bad0);
        end
    endtask

    task automatic test_burst;
        bit ok; int cyc; int c0; int w; logic [9:0] e;
        logic [7:0] bytes [3];
        bytes[0] = 8'hF0; bytes[1] = 8'h0F; bytes[2] = 8'h55;
        do_reset; step;
        ready_polls = 1;
        req_tx[15:8] = bytes[0];
        req_hold = 2'b10;
        req = 2'b10;
        w = 0;
        while (cs_n !== 2'b01 && w < 10) begin
            step;
            w++;
        end
        n_checks++;
        if (cs_n !== 2'b01) begin
            n_fail++;
            $display("FAIL burst_grant got cs_n=%b want 01", cs_n);
        end
        c0 = cs1_high;
        req[0] = 1'b1;
        req_tx[7:0] = 8'h77;
        for (int i = 0; i < 3; i++) exp_q.push_back({2'b10, bytes[i] ^ 8'h99});
        exp_q.push_back({2'b01, 8'h77 ^ 8'h99});
        for (int i = 0; i < 4; i++) begin
            wait_ack(60, ok, cyc);
            n_checks++;
            if (!ok) begin
                n_fail++;
                $display("FAIL burst_ack%0d got timeout want ack", i);
            end else begin
                e = exp_q.pop_front();
                if ({ack, rx_data} !== e) begin
                    n_fail++;
                    $display("FAIL burst_ack%0d got ack=%b rx=%h want ack=%b rx=%h",
                             i, ack, rx_data, e[9:8], e[7:0]);
                end
            end
            if (i < 2) begin
                req_tx[15:8] = bytes[i+1];
                req_hold[1] = (i == 0);
            end else if (i == 2) begin
                req[1] = 1'b0;
                n_checks++;
                if (cs1_high != c0) begin
                    n_fail++;
                    $display("FAIL burst_cs_held got %0d cycles with cs_n[1]=1 want 0", cs1_high - c0);
                end
            end
        end
        req = '0;
        step; step;
    endtask

    task automatic test_reset_mid;
        int w;
        do_reset; step;
        ready_polls = 1000;
        req_tx[7:0] = 8'hAA;
        req = 2'b01;
`ifndef SPI_XFER_ARB_TIMEOUT_EN
        w = 0;
        for (int i = 0; i < 40; i++) begin
            step;
            if (ack != '0 || !busy || err) w++;
        end
        n_checks++;
        if (w != 0) begin
            n_fail++;
            $display("FAIL stuck_spif_polls got %0d cycles with ack/idle/err want 0", w);
        end
`endif
        w = 0;
        while (!(iore && io_addr == 6'h2D) && w < 20) begin
            step;
            w++;
        end
        n_checks++;
        if (!(iore && io_addr == 6'h2D)) begin
            n_fail++;
            $display("FAIL mid_reach_poll got iore=%b addr=%h want 1 2d", iore, io_addr);
        end
        ireset = 1'b1;
        step;
        ireset = 1'b0;
        req = '0;
        #1;
        n_checks++;
        if ({cs_n, ack, iowe, io_addr, dbus_out} !== {2'b11, 2'b00, 1'b1, 6'h2C, 8'h50}) begin
            n_fail++;
            $display("FAIL mid_reset got cs_n=%b ack=%b iowe=%b addr=%h dout=%h want 11 00 1 2c 50",
                     cs_n, ack, iowe, io_addr, dbus_out);
        end
        step; step;
    endtask

`ifdef SPI_XFER_ARB_TIMEOUT_EN
    task automatic test_timeout;
        bit ok; int cyc; logic [9:0] e;
        do_reset; step;
        ready_polls = 1000;
        req_tx[7:0] = 8'h12;
        req = 2'b01;
        exp_q.push_back({2'b01, 8'hFF});
        wait_ack(100, ok, cyc);
        req = '0;
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL timeout_ack got timeout want ack");
        end else begin
            e = exp_q.pop_front();
            if ({ack, rx_data, err, polls_done} !== {e, 1'b1, 32'd4}) begin
                n_fail++;
                $display("FAIL timeout_ack got ack=%b rx=%h err=%b polls=%0d want ack=%b rx=%h err=1 polls=4",
                         ack, rx_data, err, polls_done, e[9:8], e[7:0]);
            end
        end
        step;
        n_checks++;
        if ({iowe, io_addr, cs_n, busy} !== {1'b1, 6'h2C, 2'b11, 1'b1}) begin
            n_fail++;
            $display("FAIL timeout_cfg got iowe=%b addr=%h cs_n=%b busy=%b want 1 2c 11 1",
                     iowe, io_addr, cs_n, busy);
        end
        step; step;
        n_checks++;
        if (err !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_sticky got err=%b want 1", err);
        end
        do_reset;
        n_checks++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_clear got err=%b want 0", err);
        end
    endtask
`endif

    initial begin
        test_reset;
        test_single;
        test_latency;
        test_round_robin;
        test_burst;
        test_reset_mid;
`ifdef SPI_XFER_ARB_TIMEOUT_EN
        test_timeout;
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
